// File: rtl/stopwatch_ctrl.sv
// Run-control sequencer for a 4-digit BCD stopwatch.
// Conditions the R/P buttons and sequences IDLE/RUN/PAUSE/DONE.
module stopwatch_ctrl #(
  parameter int TICK_DIV  = 1000000,
  parameter int DB_CYCLES = 2000000
) (
  input  logic        c_clk,
  input  logic        R_n,
  input  logic        btn_R,
  input  logic        btn_P,
  input  logic [1:0]  sel,
  input  logic [7:0]  load,
  input  logic [15:0] cnt_val,
  output logic        cnt_clr,
  output logic        cnt_en,
  output logic        cnt_dir,
  output logic [15:0] init_val,
  output logic [1:0]  state,
  output logic        done
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DMAX = DW'(DB_CYCLES - 1);
  localparam int BR = 0;
  localparam int BP = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  state_e              state_q;
  logic                clr_q;
  logic                done_q;
  logic                dir_q;
  logic [15:0]         init_q;
  logic [PW-1:0]       presc_q;
  logic [1:0]          s1_q;
  logic [1:0]          s2_q;
  logic [1:0]          lvl_q;
  logic [1:0]          press_q;
  logic [1:0][DW-1:0]  dbc_q;

  logic [3:0]  hi_d;
  logic [3:0]  lo_d;
  logic [15:0] init_d;
  logic [15:0] term;
  logic        at_term;

  // Debounce runs on the synchronized sample; level flips after
  // DB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge c_clk or negedge R_n) begin
    if (!R_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      lvl_q   <= '0;
      press_q <= '0;
      dbc_q   <= '0;
    end else begin
      s1_q <= {btn_P, btn_R};
      s2_q <= s1_q;
      for (int i = 0; i < 2; i++) begin
        press_q[i] <= 1'b0;
        if (s2_q[i] == lvl_q[i]) begin
          dbc_q[i] <= '0;
        end else if (dbc_q[i] == DMAX) begin
          dbc_q[i]   <= '0;
          lvl_q[i]   <= s2_q[i];
          press_q[i] <= s2_q[i];
        end else begin
          dbc_q[i] <= dbc_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    hi_d   = (load[7:4] > 4'd9) ? 4'd9 : load[7:4];
    lo_d   = (load[3:0] > 4'd9) ? 4'd9 : load[3:0];
    init_d = 16'h0000;
    unique case (sel)
      2'd0: init_d = 16'h0000;
      2'd1: init_d = {hi_d, lo_d, 8'h00};
      2'd2: init_d = 16'h9999;
      2'd3: init_d = {hi_d, lo_d, 8'h00};
    endcase
  end

  assign term    = dir_q ? 16'h0000 : 16'h9999;
  assign at_term = (cnt_val == term);

  always_ff @(posedge c_clk or negedge R_n) begin
    if (!R_n) begin
      state_q <= S_IDLE;
      clr_q   <= 1'b1;
      done_q  <= 1'b0;
      dir_q   <= 1'b0;
      init_q  <= 16'h0000;
      presc_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // Freeze the mode on the start cycle so the counter preset
          // and the latched init value always agree.
          if (press_q[BP]) begin
            state_q <= S_RUN;
            clr_q   <= 1'b0;
            presc_q <= '0;
          end else begin
            dir_q  <= sel[1];
            init_q <= init_d;
          end
        end
        S_RUN: begin
          if (press_q[BR]) begin
            state_q <= S_IDLE;
            clr_q   <= 1'b1;
          end else if (press_q[BP]) begin
            state_q <= S_PAUSE;
          end else if (at_term) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            presc_q <= (presc_q == PMAX) ? '0 : presc_q + 1'b1;
          end
        end
        S_PAUSE: begin
          if (press_q[BR]) begin
            state_q <= S_IDLE;
            clr_q   <= 1'b1;
          end else if (press_q[BP]) begin
            state_q <= S_RUN;
          end
        end
        S_DONE: begin
          if (press_q[BR]) begin
            state_q <= S_IDLE;
            clr_q   <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cnt_en   = (state_q == S_RUN) && !press_q[BR] && !press_q[BP]
                  && (presc_q == PMAX) && !at_term;
  assign cnt_clr  = clr_q;
  assign cnt_dir  = dir_q;
  assign init_val = init_q;
  assign state    = state_q;
  assign done     = done_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: BCD counter model on the outputs and a
// cycle-level behavioural reference of the controller.
module tb_stopwatch_ctrl;

  localparam int TD = 4;
  localparam int DB = 3;

  logic        c_clk = 1'b0;
  logic        R_n   = 1'b0;
  logic        btn_R = 1'b0;
  logic        btn_P = 1'b0;
  logic [1:0]  sel   = 2'd0;
  logic [7:0]  load  = 8'h00;
  logic [15:0] cnt_val = 16'h0000;
  logic        cnt_clr;
  logic        cnt_en;
  logic        cnt_dir;
  logic [15:0] init_val;
  logic [1:0]  state;
  logic        done;

  stopwatch_ctrl #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
    .c_clk    (c_clk),
    .R_n      (R_n),
    .btn_R    (btn_R),
    .btn_P    (btn_P),
    .sel      (sel),
    .load     (load),
    .cnt_val  (cnt_val),
    .cnt_clr  (cnt_clr),
    .cnt_en   (cnt_en),
    .cnt_dir  (cnt_dir),
    .init_val (init_val),
    .state    (state),
    .done     (done)
  );

  always #5 c_clk = ~c_clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] b);
    return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100
         + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int init_of(input logic [1:0] s, input logic [7:0] ld);
    int hi;
    int lo;
    hi = (int'(ld[7:4]) > 9) ? 9 : int'(ld[7:4]);
    lo = (int'(ld[3:0]) > 9) ? 9 : int'(ld[3:0]);
    if (s == 2'd0) return 0;
    if (s == 2'd2) return 9999;
    return (hi * 10 + lo) * 100;
  endfunction

  // Reference: state 0 idle, 1 run, 2 pause, 3 done; index 0 = R, 1 = P.
  int m_st;
  int m_presc;
  int m_dir;
  int m_init;
  int m_lvl [2];
  int m_run [2];
  int m_press [2];
  int m_hist [2][2];

  task automatic m_reset();
    m_st = 0; m_presc = 0; m_dir = 0; m_init = 0;
    for (int i = 0; i < 2; i++) begin
      m_lvl[i] = 0; m_run[i] = 0; m_press[i] = 0;
      m_hist[i][0] = 0; m_hist[i][1] = 0;
    end
  endtask

  task automatic m_update(input int rr, input int rp, input logic [1:0] s,
                          input logic [7:0] ld, input int cv);
    int term;
    int pr;
    int pp;
    int raw;
    int syncv;
    term = (m_dir != 0) ? 0 : 9999;
    pr = m_press[0];
    pp = m_press[1];
    case (m_st)
      0: if (pp != 0) begin m_st = 1; m_presc = 0; end
         else begin m_dir = int'(s[1]); m_init = init_of(s, ld); end
      1: if (pr != 0) m_st = 0;
         else if (pp != 0) m_st = 2;
         else if (cv == term) m_st = 3;
         else m_presc = (m_presc + 1) % TD;
      2: if (pr != 0) m_st = 0; else if (pp != 0) m_st = 1;
      default: if (pr != 0) m_st = 0;
    endcase
    for (int i = 0; i < 2; i++) begin
      raw = (i == 0) ? rr : rp;
      syncv = m_hist[i][1];
      m_hist[i][1] = m_hist[i][0];
      m_hist[i][0] = raw;
      m_press[i] = 0;
      if (syncv == m_lvl[i]) m_run[i] = 0;
      else m_run[i]++;
      if (m_run[i] == DB) begin
        m_lvl[i] = syncv; m_run[i] = 0; m_press[i] = syncv;
      end
    end
  endtask

  task automatic step();
    logic en_s, clr_s, dir_s;
    logic [15:0] iv_s;
    int cv, rr, rp, v, exp_en, term;
    logic [1:0] s;
    logic [7:0] ld;
    en_s = cnt_en; clr_s = cnt_clr; dir_s = cnt_dir; iv_s = init_val;
    cv = bcd2int(cnt_val); rr = int'(btn_R); rp = int'(btn_P);
    s = sel; ld = load;
    @(posedge c_clk);
    #1;
    if (clr_s) cnt_val = iv_s;
    else if (en_s) begin
      v = dir_s ? (cv + 9999) % 10000 : (cv + 1) % 10000;
      cnt_val = int2bcd(v);
    end
    if (!R_n) m_reset();
    else m_update(rr, rp, s, ld, cv);
    #1;
    term = (m_dir != 0) ? 0 : 9999;
    exp_en = (m_st == 1 && m_press[0] == 0 && m_press[1] == 0
              && m_presc == TD - 1 && bcd2int(cnt_val) != term) ? 1 : 0;
    chk("state", 32'(state), 32'(m_st));
    chk("cnt_clr", 32'(cnt_clr), (m_st == 0) ? 32'd1 : 32'd0);
    chk("done", 32'(done), (m_st == 3) ? 32'd1 : 32'd0);
    chk("cnt_dir", 32'(cnt_dir), 32'(m_dir));
    chk("init_val", 32'(init_val), 32'(int2bcd(m_init)));
    chk("cnt_en", 32'(cnt_en), 32'(exp_en));
  endtask

  task automatic cyc(input int n);
    repeat (n) step();
  endtask

  task automatic wait_st(input logic [1:0] s, input int maxc,
                         input string tag);
    int k;
    k = 0;
    while (state !== s && k < maxc) begin
      step();
      k++;
    end
    chk(tag, 32'(state), 32'(s));
  endtask

  task automatic start_run(input string tag);
    btn_P = 1'b1;
    wait_st(2'd1, 20, tag);
    btn_P = 1'b0;
    cyc(8);
  endtask

  task automatic go_idle(input string tag);
    btn_R = 1'b1;
    wait_st(2'd0, 20, tag);
    btn_R = 1'b0;
    cyc(8);
  endtask

  initial begin
    int pulses, bad, k, t0, t1, hp, hr;
    m_reset();
    cyc(3);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_clr", 32'(cnt_clr), 32'd1);
    chk("rst_init", 32'(init_val), 32'h0);
    R_n = 1'b1;
    pulses = 0;
    repeat (50) begin
      step();
      if (cnt_en) pulses++;
    end
    chk("idle_no_tick", 32'(pulses), 32'd0);

    btn_P = 1'b1; cyc(2); btn_P = 1'b0; cyc(10);
    chk("glitch_idle", 32'(state), 32'd0);

    btn_P = 1'b1; cyc(5);
    chk("lat5_idle", 32'(state), 32'd0);
    cyc(1);
    chk("lat6_run", 32'(state), 32'd1);
    cyc(1); btn_P = 1'b0;

    k = 0;
    while (cnt_val !== 16'h0002 && k < 40) begin step(); k++; end
    chk("reach2", 32'(cnt_val), 32'h2);
    btn_P = 1'b1;
    wait_st(2'd2, 20, "to_pause");
    btn_P = 1'b0;
    chk("pause_val", 32'(cnt_val), 32'h3);
    bad = 0;
    repeat (40) begin
      step();
      if (cnt_val !== 16'h0003) bad++;
    end
    chk("pause_hold", 32'(bad), 32'd0);
    btn_P = 1'b1;
    wait_st(2'd1, 20, "resume");
    btn_P = 1'b0;
    k = 0;
    while (cnt_val === 16'h0003 && k < 10) begin step(); k++; end
    chk("resume_next", 32'(cnt_val), 32'h4);
    t0 = -1; t1 = -1;
    for (int i = 0; i < 20 && t1 < 0; i++) begin
      step();
      if (cnt_en) begin
        if (t0 < 0) t0 = i; else t1 = i;
      end
    end
    chk("tick_period", 32'(t1 - t0), 32'd4);
    go_idle("r_idle");

    sel = 2'd3; load = 8'h01; cyc(3);
    chk("m3_init", 32'(init_val), 32'h0100);
    chk("m3_dir", 32'(cnt_dir), 32'd1);
    start_run("m3_run");
    wait_st(2'd3, 600, "m3_done");
    chk("m3_done_o", 32'(done), 32'd1);
    chk("m3_zero", 32'(cnt_val), 32'h0);
    btn_P = 1'b1; cyc(10); btn_P = 1'b0; cyc(10);
    chk("m3_p_ign", 32'(state), 32'd3);
    chk("m3_hold0", 32'(cnt_val), 32'h0);
    btn_R = 1'b1;
    wait_st(2'd0, 20, "m3_r_idle");
    btn_R = 1'b0;
    chk("m3_clr", 32'(cnt_clr), 32'd1);
    cyc(8);

    sel = 2'd1; load = 8'hA5; cyc(3);
    chk("clamp_init", 32'(init_val), 32'h9500);
    start_run("m1_run");
    sel = 2'd2; load = 8'h00; cyc(10);
    chk("latch_dir", 32'(cnt_dir), 32'd0);
    chk("latch_init", 32'(init_val), 32'h9500);
    wait_st(2'd3, 2500, "m1_done");
    chk("m1_term", 32'(cnt_val), 32'h9999);
    go_idle("m1_idle");

    sel = 2'd0; load = 8'h00; cyc(3);
    start_run("prio_run");
    btn_R = 1'b1; btn_P = 1'b1; cyc(6);
    chk("prio_idle", 32'(state), 32'd0);
    btn_R = 1'b0; btn_P = 1'b0; cyc(8);

    start_run("arst_run");
    #2;
    R_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_clr", 32'(cnt_clr), 32'd1);
    chk("arst_en", 32'(cnt_en), 32'd0);
    chk("arst_dir", 32'(cnt_dir), 32'd0);
    chk("arst_init", 32'(init_val), 32'h0);
    chk("arst_done", 32'(done), 32'd0);
    cyc(2);
    R_n = 1'b1;
    cyc(8);

    hp = 0; hr = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hp == 0) begin
        btn_P = ($urandom_range(0, 5) == 0);
        hp = $urandom_range(1, 12);
      end else hp--;
      if (hr == 0) begin
        btn_R = ($urandom_range(0, 30) == 0);
        hr = $urandom_range(1, 12);
      end else hr--;
      if ($urandom_range(0, 60) == 0) begin
        sel = 2'($urandom_range(0, 3));
        load = 8'($urandom);
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
